// File: rtl/psum_accum.sv
// psum_accum: per-tile partial-sum accumulator with requantised 8-bit output.
// Sums psum_in over cfg_passes passes of cfg_len entries, seeds each entry
// with bias on pass 0, and emits requant(sum) for every entry on the final pass.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cfg_start/len/passes/shift/relu, bias   tile configuration (latched on start)
//   psum_in/psum_valid/psum_ready  partial-sum input stream
//   out_data/out_valid/out_ready   requantised output stream
//   busy, done, cfg_err            status (done/cfg_err are one-cycle pulses)
module psum_accum #(
   parameter int unsigned PSW   = 11,
   parameter int unsigned ACCW  = 24,
   parameter int unsigned DEPTH = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_start,
   input  logic [$clog2(DEPTH):0]        cfg_len,
   input  logic [7:0]                    cfg_passes,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_relu,
   input  logic signed [15:0]            bias,
   input  logic signed [PSW-1:0]         psum_in,
   input  logic                          psum_valid,
   output logic                          psum_ready,
   output logic [7:0]                    out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          cfg_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned RW = ACCW + 1;
   localparam logic signed [RW-1:0] SAT_HI = RW'(127);
   localparam logic signed [RW-1:0] SAT_LO = RW'(-128);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_LAST  = 2'd2,
      S_FLUSH = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [AW-1:0]           idx_q, idx_d;
   logic [7:0]              pass_q, pass_d;
   logic [LW-1:0]           len_q, len_d;
   logic [7:0]              passes_q, passes_d;
   logic [4:0]              shift_q, shift_d;
   logic                    relu_q, relu_d;
   logic signed [15:0]      bias_q, bias_d;
   logic [7:0]              out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    cfg_err_q, cfg_err_d;

   logic signed [ACCW-1:0]  acc_q [DEPTH];

   logic                    psum_ready_c;
   logic                    xfer_c;
   logic                    last_idx_c;
   logic                    cfg_ok_c;
   logic signed [ACCW-1:0]  base_c;
   logic signed [ACCW-1:0]  sum_c;
   logic signed [RW-1:0]    half_c;
   logic signed [RW-1:0]    rnd_c;
   logic signed [RW-1:0]    shr_c;
   logic [7:0]              quant_c;

   // Input acceptance: in the final pass, a new psum may only land if the
   // output register is free or being drained this cycle.
   always_comb begin
      psum_ready_c = 1'b0;
      unique case (state_q)
         S_ACCUM: psum_ready_c = 1'b1;
         S_LAST:  psum_ready_c = !out_valid_q || out_ready;
         default: psum_ready_c = 1'b0;
      endcase
   end

   assign xfer_c     = psum_valid && psum_ready_c;
   assign last_idx_c = (LW'(idx_q) == (len_q - LW'(1)));
   assign cfg_ok_c   = (cfg_len != '0) && (cfg_len <= LW'(DEPTH)) && (cfg_passes != 8'd0);

   // Accumulate and requantise (round-half-up, arithmetic shift, ReLU, saturate).
   always_comb begin
      base_c = (pass_q == 8'd0) ? ACCW'(bias_q) : acc_q[idx_q];
      sum_c  = base_c + ACCW'(psum_in);
      half_c = '0;
      if (shift_q != 5'd0) begin
         half_c = RW'(1) << (shift_q - 5'd1);
      end
      rnd_c = RW'(sum_c) + half_c;
      shr_c = rnd_c >>> shift_q;
      if (relu_q && shr_c[RW-1]) begin
         shr_c = '0;
      end
      if (shr_c > SAT_HI) begin
         quant_c = 8'h7f;
      end else if (shr_c < SAT_LO) begin
         quant_c = 8'h80;
      end else begin
         quant_c = shr_c[7:0];
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pass_d      = pass_q;
      len_d       = len_q;
      passes_d    = passes_q;
      shift_d     = shift_q;
      relu_d      = relu_q;
      bias_d      = bias_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !out_ready;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               if (cfg_ok_c) begin
                  len_d    = cfg_len;
                  passes_d = cfg_passes;
                  shift_d  = cfg_shift;
                  relu_d   = cfg_relu;
                  bias_d   = bias;
                  idx_d    = '0;
                  pass_d   = 8'd0;
                  state_d  = (cfg_passes == 8'd1) ? S_LAST : S_ACCUM;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_ACCUM: begin
            if (xfer_c) begin
               if (last_idx_c) begin
                  idx_d  = '0;
                  pass_d = pass_q + 8'd1;
                  if ((pass_q + 8'd1) == (passes_q - 8'd1)) begin
                     state_d = S_LAST;
                  end
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         S_LAST: begin
            if (xfer_c) begin
               out_valid_d = 1'b1;
               out_data_d  = quant_c;
               if (last_idx_c) begin
                  idx_d   = '0;
                  state_d = S_FLUSH;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         S_FLUSH: begin
            if (out_valid_q && out_ready) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         pass_q      <= 8'd0;
         len_q       <= '0;
         passes_q    <= 8'd0;
         shift_q     <= 5'd0;
         relu_q      <= 1'b0;
         bias_q      <= '0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pass_q      <= pass_d;
         len_q       <= len_d;
         passes_q    <= passes_d;
         shift_q     <= shift_d;
         relu_q      <= relu_d;
         bias_q      <= bias_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Accumulator storage needs no reset: pass 0 overwrites every used entry.
   always_ff @(posedge clk) begin
      if (xfer_c) begin
         acc_q[idx_q] <= sum_c;
      end
   end

   assign psum_ready = psum_ready_c;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 SHALL have parameter PSW, default 11, meaning signed partial-sum width from the MAC column.
REQ-002 SHALL have parameter ACCW, default 24, meaning signed accumulator width.
REQ-003 SHALL have parameter DEPTH, default 64, meaning accumulator entries (output pixels per tile); AW = clog2(DEPTH).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cfg_start  input  1  one-cycle pulse that starts a tile; sampled only in IDLE.
REQ-007 cfg_len  input  AW+1  entries per pass, 1..DEPTH; latched on an accepted start.
REQ-008 cfg_passes  input  8  passes (input-channel groups) per tile, 1..255; latched on start.
REQ-009 cfg_shift  input  5  requantise right-shift, 0..23; latched on start.
REQ-010 cfg_relu  input  1  ReLU enable; latched on start.
REQ-011 bias  input  16  signed bias, added once per entry; latched on start.
REQ-012 psum_in  input  PSW  signed partial sum from the systolic column.
REQ-013 psum_valid  input  1  psum_in valid.
REQ-014 psum_ready  output  1  block accepts psum_in this cycle.
REQ-015 out_data  output  8  signed requantised result.
REQ-016 out_valid  output  1  out_data valid.
REQ-017 out_ready  input  1  downstream accepts out_data.
REQ-018 busy  output  1  high outside IDLE.
REQ-019 done  output  1  one-cycle pulse when the tile completes.
REQ-020 cfg_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-021 FSM states SHALL be IDLE, ACCUM (pass < cfg_passes-1), LAST (final pass) and FLUSH (last output pending).
REQ-022 IDLE + cfg_start with cfg_len in 1..DEPTH and cfg_passes≠0 SHALL latch config, clear idx and pass, and enter ACCUM, or LAST if cfg_passes==1.
REQ-023 IDLE + cfg_start with cfg_len==0, cfg_len>DEPTH or cfg_passes==0 SHALL pulse cfg_err the next cycle and stay in IDLE.
REQ-024 A psum transfer SHALL occur when psum_valid && psum_ready; idx increments per transfer and wraps to 0 after cfg_len-1.
REQ-025 On transfer, acc[idx] SHALL become sext(bias)+sext(psum_in) on pass 0, else acc[idx]+sext(psum_in), wrapping modulo 2^ACCW.
REQ-026 psum_ready SHALL be 1 in ACCUM, (!out_valid || out_ready) in LAST, and 0 in IDLE and FLUSH.
REQ-027 Wrap of idx SHALL increment pass; if the new pass equals cfg_passes-1, state moves ACCUM->LAST.
REQ-028 In LAST, each transfer SHALL load out_data/out_valid on the next edge (latency 1 cycle) with requant(sum), where sum is the value REQ-025 would store.
REQ-029 requant SHALL be: add 2^(cfg_shift-1) if cfg_shift>0; arithmetic shift right by cfg_shift; if cfg_relu, negative->0; saturate to [-128,127].
REQ-030 out_valid SHALL hold, with out_data stable, until out_ready; it clears on handshake unless reloaded in the same cycle.
REQ-031 The transfer of entry cfg_len-1 in LAST SHALL move to FLUSH; FLUSH waits for the final output handshake.
REQ-032 On that handshake, the block SHALL pulse done for one cycle and enter IDLE.
REQ-033 cfg_start outside IDLE SHALL be ignored with no cfg_err.
REQ-034 Transfers SHALL NOT occur in IDLE or FLUSH regardless of psum_valid.

Reset
REQ-035 Reset SHALL force IDLE, idx=0, pass=0, psum_ready=0, out_valid=0, out_data=0, busy=0, done=0 and cfg_err=0, aborting any tile in progress.
REQ-036 acc contents SHALL NOT require reset; pass 0 overwrites every used entry.

Verification
REQ-037 passes=1, len=4, bias=0, shift=0, relu=0, psums 5,-3,127,200 -> outputs 5,-3,127,127 with each 1 cycle after its transfer, done after the 4th handshake.
REQ-038 passes=3, len=2, bias=10, shift=2, relu=1, entry0 psums 100,100,100 and entry1 -200,-200,-200 -> outputs 78 then 0.
REQ-039 LAST with out_ready low for 5 cycles -> psum_ready=0 and out_data held stable; transfers resume the cycle out_ready rises.
REQ-040 cfg_start with cfg_len=0 -> cfg_err pulse and busy stays 0; cfg_start while busy -> ignored and the tile completes unchanged.
REQ-041 rst_n low mid-ACCUM, then a new tile with passes=1, len=1, bias=-5, psum=2 -> out_data=-3 and no stale accumulator contribution.
REQ-042 shift=4, psum=-24, passes=1, bias=0, relu=0 -> out_data=-1 (round-half-up: (-24+8)>>4 = -1).
